// File: rtl/conv_mem_reader_if.sv
// Bundles the conv_mem_reader request/response and memory-read signals.
// Latency: none; this file holds only wires and modports.
// Backpressure: none; start_mem is a level request and stays high until done_mem.
//
// Signals:
//   start_mem  level request from the conv control unit
//   base_addr  first word address of the 3x3 window
//   mem_rd     memory read strobe
//   mem_addr   memory read address
//   mem_data   memory read data, valid the cycle after mem_rd/mem_addr
//   win_data   window register file, word i at [i*DATA_W +: DATA_W]
//   done_mem   one-cycle completion pulse
//   busy       high whenever the reader is not idle
// master = control unit plus memory side; slave = the reader.
interface conv_mem_reader_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int NWORDS = 9
);
   logic                       start_mem;
   logic [ADDR_W-1:0]          base_addr;
   logic                       mem_rd;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_data;
   logic [NWORDS*DATA_W-1:0]   win_data;
   logic                       done_mem;
   logic                       busy;

   modport master (
      output start_mem,
      output base_addr,
      output mem_data,
      input  mem_rd,
      input  mem_addr,
      input  win_data,
      input  done_mem,
      input  busy
   );

   modport slave (
      input  start_mem,
      input  base_addr,
      input  mem_data,
      output mem_rd,
      output mem_addr,
      output win_data,
      output done_mem,
      output busy
   );
endinterface

// File: rtl/conv_mem_reader.sv
// Fetches NWORDS consecutive memory words starting at base_addr into a window register file.
// Latency: request sampled at edge 0, reads in cycles 1..NWORDS, done_mem in cycle NWORDS+2.
// Backpressure: none; dropping start_mem during READ/DRAIN aborts, a held start_mem never re-triggers.
//
// Ports:
//   clk  single clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  conv_mem_reader_if slave modport (start_mem, base_addr, mem_rd, mem_addr,
//        mem_data, win_data, done_mem, busy)
module conv_mem_reader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int NWORDS = 9
) (
   input  logic             clk,
   input  logic             rst,
   conv_mem_reader_if.slave bus
);

   localparam int               CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NWORDS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE,
      ST_HOLD
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_base;

   // Capture pipeline: the word addressed in one cycle lands on mem_data in
   // the next, so the index of the outstanding read is carried one cycle.
   logic                r_cap_vld;
   logic [CNT_W-1:0]    r_cap_idx;

   logic [DATA_W-1:0]   r_win [NWORDS];

   logic                w_accept;
   logic                w_abort;
   logic                w_mem_rd;
   logic                w_done;
   logic                w_capture;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [NWORDS*DATA_W-1:0] w_win;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and decoded controls
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_abort     = 1'b0;
      w_mem_rd    = 1'b0;
      w_done      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.start_mem) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_READ;
            end
         end

         ST_READ: begin
            w_mem_rd = 1'b1;
            if (!bus.start_mem) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == LAST) begin
               w_state_nxt = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (!bus.start_mem) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = ST_HOLD;
         end

         ST_HOLD: begin
            // A level that is still high after completion must not start a
            // second fetch; the control unit has to drop it first.
            if (!bus.start_mem) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Address wraps naturally at 2^ADDR_W.
   assign w_mem_addr = w_mem_rd ? (r_base + ADDR_W'(r_cnt)) : '0;

   // The pending word is dropped if the request is abandoned in this cycle.
   assign w_capture  = r_cap_vld && !w_abort;

   // ------------------------------------------------------------------
   // Base address latch and word counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_base <= bus.base_addr;
         r_cnt  <= '0;
      end else if (r_state == ST_READ) begin
         if (w_abort || (r_cnt == LAST)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Outstanding-read tracker
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_vld <= 1'b0;
         r_cap_idx <= '0;
      end else begin
         r_cap_vld <= w_mem_rd && !w_abort;
         r_cap_idx <= r_cnt;
      end
   end

   // ------------------------------------------------------------------
   // Window register file: only the addressed word is written
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NWORDS; i++) begin
            r_win[i] <= '0;
         end
      end else if (w_capture) begin
         for (int i = 0; i < NWORDS; i++) begin
            if (r_cap_idx == CNT_W'(i)) begin
               r_win[i] <= bus.mem_data;
            end
         end
      end
   end

   always_comb begin
      w_win = '0;
      for (int i = 0; i < NWORDS; i++) begin
         w_win[i*DATA_W +: DATA_W] = r_win[i];
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.mem_rd   = w_mem_rd;
   assign bus.mem_addr = w_mem_addr;
   assign bus.win_data = w_win;
   assign bus.done_mem = w_done;
   assign bus.busy     = (r_state != ST_IDLE);

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_cnt_range: assert property (@(posedge clk) disable iff (rst) r_cnt <= LAST);
   a_done_hold: assert property (@(posedge clk) disable iff (rst)
                                 (r_state == ST_DONE) |=> (r_state == ST_HOLD));

endmodule

// File: tb/tb_conv_mem_reader.sv
// Randomized scoreboard bench for conv_mem_reader.
// The driver issues requests and pushes expected addresses/windows into queues.
// A negedge monitor pops and compares whenever the DUT reads or goes idle.
module tb_conv_mem_reader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int NWORDS = 9;
   localparam int WIN_W  = NWORDS * DATA_W;

   typedef struct {
      bit               done;
      int               cyc;
      logic [WIN_W-1:0] win;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   conv_mem_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) bus ();

   conv_mem_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NWORDS(NWORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DATA_W-1:0] mem [256];
   logic [WIN_W-1:0]  mdl_win = '0;
   logic [ADDR_W-1:0] addr_q [$];
   exp_t              exp_q [$];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
      end
   endtask

   // Memory: samples the read request mid-cycle, returns data just after the edge.
   logic              rd_q   = 1'b0;
   logic [ADDR_W-1:0] addr_s = '0;
   always @(negedge clk) begin
      rd_q   = bus.mem_rd;
      addr_s = bus.mem_addr;
   end
   always @(posedge clk) begin
      #1;
      if (rd_q) bus.mem_data = mem[addr_s];
      else      bus.mem_data = DATA_W'($urandom);
   end

   // Monitor
   bit               prev_busy = 1'b0;
   int               done_cnt  = 0;
   int               done_at   = -1;
   bit               have_ref  = 1'b0;
   logic [WIN_W-1:0] ref_win   = '0;
   exp_t             mon_e;

   always @(negedge clk) begin
      if (bus.mem_rd === 1'b1) begin
         if (addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_rd actual=addr %0h required=no read cycle=%0d", bus.mem_addr, cyc);
         end else begin
            chk("mem_addr", bus.mem_addr, addr_q.pop_front());
         end
      end else begin
         chk("mem_addr_idle", bus.mem_addr, '0);
      end

      if (bus.done_mem === 1'b1) begin
         done_cnt++;
         done_at = cyc;
         if (exp_q.size() > 0) chk("win_at_done", bus.win_data, exp_q[0].win);
      end

      if (prev_busy && !bus.busy) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_idle actual=busy fell required=no request cycle=%0d", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done_count", done_cnt, mon_e.done ? 1 : 0);
            if (mon_e.done) chk("done_cycle", done_at, mon_e.cyc);
            chk("win_data", bus.win_data, mon_e.win);
            ref_win  = mon_e.win;
            have_ref = 1'b1;
         end
         done_cnt = 0;
      end else if (!bus.busy && have_ref) begin
         chk("win_hold", bus.win_data, ref_win);
      end
      prev_busy = bus.busy;
   end

   // Reference model: a request reads base+k for every READ cycle it reaches,
   // and word k lands only if start_mem is still high in cycle k+2.
   task automatic expect_req(input logic [ADDR_W-1:0] base, input int abort, input int e0);
      exp_t e;
      int   nrd;
      nrd = (abort == 0 || abort > NWORDS) ? NWORDS : abort;
      for (int k = 0; k < nrd; k++) addr_q.push_back(base + ADDR_W'(k));
      for (int k = 0; k < NWORDS; k++)
         if (abort == 0 || k + 2 < abort) mdl_win[k*DATA_W +: DATA_W] = mem[base + ADDR_W'(k)];
      e.done = (abort == 0);
      e.cyc  = e0 + NWORDS + 1;
      e.win  = mdl_win;
      exp_q.push_back(e);
   endtask

   // Called at edge 0; waits for done_mem, holds start_mem, then drops it.
   task automatic finish_req(input int hold, input int gap);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 4 * NWORDS) begin
         #1 bus.base_addr = ADDR_W'($urandom);
         @(negedge clk);
         if (bus.done_mem === 1'b1) seen = 1'b1;
         @(posedge clk);
         n++;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL done_wait actual=no done_mem required=done_mem within %0d cycles", 4 * NWORDS);
      end
      repeat (hold) @(posedge clk);
      #1 bus.start_mem = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic run_req(input logic [ADDR_W-1:0] base, input int abort, input int hold, input int gap);
      @(posedge clk);
      #1;
      bus.base_addr = base;
      bus.start_mem = 1'b1;
      expect_req(base, abort, cyc + 1);
      @(posedge clk);
      if (abort > 0) begin
         repeat (abort - 1) begin
            #1 bus.base_addr = ADDR_W'($urandom);
            @(posedge clk);
         end
         #1 bus.start_mem = 1'b0;
         repeat (gap) @(posedge clk);
      end else begin
         finish_req(hold, gap);
      end
   endtask

   task automatic init_mem_x3();
      for (int a = 0; a < 256; a++) mem[a] = DATA_W'(a * 3);
   endtask

   // Reset during cycle 6 of a request, start_mem kept high so a fresh request follows.
   task automatic run_reset_case();
      exp_t e;
      @(posedge clk);
      #1;
      bus.base_addr = 8'h20;
      bus.start_mem = 1'b1;
      for (int k = 0; k < 5; k++) addr_q.push_back(ADDR_W'(8'h20 + k));
      mdl_win = '0;
      e.done  = 1'b0;
      e.cyc   = 0;
      e.win   = '0;
      exp_q.push_back(e);
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_rd", bus.mem_rd, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_done", bus.done_mem, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_win", bus.win_data, '0);
      bus.base_addr = 8'h10;
      init_mem_x3();
      @(posedge clk);
      #2 rst = 1'b0;
      expect_req(8'h10, 0, cyc + 1);
      @(posedge clk);
      finish_req(0, 1);
      chk("rerun_w0", bus.win_data[15:0], 16'h0030);
      chk("rerun_w8", bus.win_data[143:128], 16'h0048);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=still running required=finished cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      logic [WIN_W-1:0] prev;
      int               ab;
      bus.start_mem = 1'b0;
      bus.base_addr = '0;
      bus.mem_data  = '0;
      init_mem_x3();

      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_mem_rd", bus.mem_rd, 0);
      chk("reset_mem_addr", bus.mem_addr, 0);
      chk("reset_done", bus.done_mem, 0);
      chk("reset_win", bus.win_data, '0);
      @(posedge clk);
      #2 rst = 1'b0;

      // Basic window
      run_req(8'h10, 0, 0, 2);
      chk("basic_w0", bus.win_data[15:0], 16'h0030);
      chk("basic_w1", bus.win_data[31:16], 16'h0033);
      chk("basic_w8", bus.win_data[143:128], 16'h0048);

      // Address wrap
      run_req(8'hFC, 0, 1, 1);
      chk("wrap_w3", bus.win_data[63:48], 16'h02FD);
      chk("wrap_w4", bus.win_data[79:64], mem[0]);

      // Held start after done
      run_req(8'h33, 0, 5, 1);

      // Abort in cycle 4
      prev = bus.win_data;
      run_req(8'h50, 4, 0, 3);
      chk("abort_w0", bus.win_data[15:0], 16'h00F0);
      chk("abort_w1", bus.win_data[31:16], 16'h00F3);
      chk("abort_w2_kept", bus.win_data[47:32], prev[47:32]);
      chk("abort_w3_8_kept", bus.win_data[143:48], prev[143:48]);

      // Reset mid-request then rerun
      run_reset_case();

      // Back-to-back
      run_req(8'h20, 0, 0, 0);
      run_req(8'h40, 0, 0, 0);
      chk("b2b_w0", bus.win_data[15:0], 16'h00C0);

      // Randomized requests
      for (int r = 0; r < 40; r++) begin
         for (int a = 0; a < 256; a++) mem[a] = DATA_W'($urandom);
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NWORDS + 1) : 0;
         run_req(ADDR_W'($urandom), ab, $urandom_range(0, 5), $urandom_range(0, 3));
      end

      repeat (6) @(posedge clk);
      chk("addr_q_empty", addr_q.size(), 0);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
